// File: rtl/cpu_ctl_mc_pkg.sv
// Shared encodings for the multicycle CPU controller: FSM states, ALU ops,
// next-PC selects, exception codes and the MIPS opcode/func subset.
package cpu_ctl_mc_pkg;

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EX  = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4,
      S_EXC = 3'd5
   } state_t;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_NOR  = 4'd5;
   localparam logic [3:0] ALU_SLT  = 4'd6;
   localparam logic [3:0] ALU_SLTU = 4'd7;
   localparam logic [3:0] ALU_SLL  = 4'd8;
   localparam logic [3:0] ALU_SRL  = 4'd9;
   localparam logic [3:0] ALU_SRA  = 4'd10;
   localparam logic [3:0] ALU_LUI  = 4'd11;

   localparam logic [1:0] PC_SEQ = 2'd0;
   localparam logic [1:0] PC_BR  = 2'd1;
   localparam logic [1:0] PC_JMP = 2'd2;
   localparam logic [1:0] PC_EXC = 2'd3;

   localparam logic [1:0] EXC_NONE = 2'd0;
   localparam logic [1:0] EXC_ILL  = 2'd1;
   localparam logic [1:0] EXC_BUS  = 2'd2;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0a;
   localparam logic [5:0] OP_SLTIU = 6'h0b;
   localparam logic [5:0] OP_ANDI  = 6'h0c;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_XORI  = 6'h0e;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2a;
   localparam logic [5:0] FN_SLTU = 6'h2b;

   function automatic logic legal_func(input logic [5:0] f);
      return f inside {FN_SLL, FN_SRL, FN_SRA, FN_JR, FN_ADD, FN_ADDU, FN_SUB,
                       FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU};
   endfunction

   // Legal I-type opcodes, branches included.
   function automatic logic is_itype(input logic [5:0] o);
      return o inside {OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI,
                       OP_XORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_BNE};
   endfunction

endpackage

// File: rtl/cpu_ctl_mc_alu_dec.sv
// ALU operation decode from opcode/func; anything without an ALU meaning
// (jumps, illegal encodings) falls back to ADD.
module alu_dec
   import cpu_ctl_mc_pkg::*;
#(
   parameter int ALUC_W = 5
) (
   input  logic [5:0]        op,
   input  logic [5:0]        func,
   output logic [ALUC_W-1:0] aluc
);

   always_comb begin
      aluc = ALUC_W'(ALU_ADD);
      case (op)
         OP_RTYPE: begin
            case (func)
               FN_SUB, FN_SUBU: aluc = ALUC_W'(ALU_SUB);
               FN_AND:          aluc = ALUC_W'(ALU_AND);
               FN_OR:           aluc = ALUC_W'(ALU_OR);
               FN_XOR:          aluc = ALUC_W'(ALU_XOR);
               FN_NOR:          aluc = ALUC_W'(ALU_NOR);
               FN_SLT:          aluc = ALUC_W'(ALU_SLT);
               FN_SLTU:         aluc = ALUC_W'(ALU_SLTU);
               FN_SLL:          aluc = ALUC_W'(ALU_SLL);
               FN_SRL:          aluc = ALUC_W'(ALU_SRL);
               FN_SRA:          aluc = ALUC_W'(ALU_SRA);
               default:         aluc = ALUC_W'(ALU_ADD);
            endcase
         end
         OP_BEQ, OP_BNE:   aluc = ALUC_W'(ALU_SUB);
         OP_ANDI:          aluc = ALUC_W'(ALU_AND);
         OP_ORI:           aluc = ALUC_W'(ALU_OR);
         OP_XORI:          aluc = ALUC_W'(ALU_XOR);
         OP_SLTI:          aluc = ALUC_W'(ALU_SLT);
         OP_SLTIU:         aluc = ALUC_W'(ALU_SLTU);
         OP_LUI:           aluc = ALUC_W'(ALU_LUI);
         default:          aluc = ALUC_W'(ALU_ADD);
      endcase
   end

endmodule

// File: rtl/cpu_ctl_mc.sv
// Multicycle MIPS-subset controller: IF/ID/EX/MEM/WB sequencing, memory
// wait timeout, illegal-instruction and bus-fault exceptions.
module cpu_ctl_mc
   import cpu_ctl_mc_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int ALUC_W      = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [5:0]        op,
   input  logic [5:0]        func,
   input  logic              equal_result,
   input  logic              mem_ready,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic              iord,
   output logic              ir_we,
   output logic              pc_we,
   output logic [1:0]        pcsrc,
   output logic              jr,
   output logic              jal,
   output logic              lw,
   output logic              wreg,
   output logic              rdorrt,
   output logic              se,
   output logic              sa,
   output logic              iorr,
   output logic [ALUC_W-1:0] aluc,
   output logic              exc,
   output logic [1:0]        exc_code,
   output logic              retire,
   output logic [2:0]        state
);

   state_t     st_q, st_d;
   logic [7:0] wcnt_q;
   logic [1:0] code_q, code_d;
   logic       run_q;
   logic       is_r, is_jr, is_j, is_jal, is_beq, is_bne, is_lw, is_sw;
   logic       is_i, legal, tmo;

   assign is_r   = (op == OP_RTYPE);
   assign is_jr  = is_r && (func == FN_JR);
   assign is_j   = (op == OP_J);
   assign is_jal = (op == OP_JAL);
   assign is_beq = (op == OP_BEQ);
   assign is_bne = (op == OP_BNE);
   assign is_lw  = (op == OP_LW);
   assign is_sw  = (op == OP_SW);
   assign is_i   = is_itype(op);
   assign legal  = is_r ? legal_func(func) : (is_i | is_j | is_jal);

   assign jr     = is_jr;
   assign jal    = is_jal;
   assign lw     = is_lw;
   assign rdorrt = is_r && !is_jr;
   assign se     = op inside {OP_ADDI, OP_ADDIU, OP_LW, OP_SW, OP_SLTI, OP_SLTIU};
   assign sa     = is_r && (func inside {FN_SLL, FN_SRL, FN_SRA});
   assign iorr   = is_i && !is_beq && !is_bne;

   alu_dec #(.ALUC_W(ALUC_W)) u_alu_dec (
      .op   (op),
      .func (func),
      .aluc (aluc)
   );

   // A ready pulse in the timeout cycle still completes the access.
   assign tmo = !mem_ready && (wcnt_q == 8'(MEM_TIMEOUT - 1));

   // run_q holds everything quiet until the first clock after reset release.
   always_comb begin
      st_d   = st_q;
      code_d = code_q;
      mem_rd = 1'b0;
      mem_wr = 1'b0;
      iord   = 1'b0;
      ir_we  = 1'b0;
      pc_we  = 1'b0;
      pcsrc  = PC_SEQ;
      wreg   = 1'b0;
      exc    = 1'b0;
      retire = 1'b0;
      if (run_q) begin
         case (st_q)
            S_IF: begin
               mem_rd = 1'b1;
               if (mem_ready) begin
                  ir_we = 1'b1;
                  pc_we = 1'b1;
                  st_d  = S_ID;
               end else if (tmo) begin
                  st_d   = S_EXC;
                  code_d = EXC_BUS;
               end
            end
            S_ID: begin
               if (!legal) begin
                  st_d   = S_EXC;
                  code_d = EXC_ILL;
               end else if (is_j || is_jal || is_jr) begin
                  pc_we  = 1'b1;
                  pcsrc  = PC_JMP;
                  wreg   = is_jal;
                  retire = 1'b1;
                  st_d   = S_IF;
               end else begin
                  st_d = S_EX;
               end
            end
            S_EX: begin
               if (is_beq || is_bne) begin
                  pc_we  = (is_beq & equal_result) | (is_bne & ~equal_result);
                  pcsrc  = PC_BR;
                  retire = 1'b1;
                  st_d   = S_IF;
               end else if (is_lw || is_sw) begin
                  st_d = S_MEM;
               end else begin
                  st_d = S_WB;
               end
            end
            S_MEM: begin
               iord   = 1'b1;
               mem_rd = is_lw;
               mem_wr = is_sw;
               if (mem_ready) begin
                  retire = is_sw;
                  st_d   = is_sw ? S_IF : S_WB;
               end else if (tmo) begin
                  st_d   = S_EXC;
                  code_d = EXC_BUS;
               end
            end
            S_WB: begin
               wreg   = 1'b1;
               retire = 1'b1;
               st_d   = S_IF;
            end
            S_EXC: begin
               exc   = 1'b1;
               pc_we = 1'b1;
               pcsrc = PC_EXC;
               st_d  = S_IF;
            end
            default: st_d = S_IF;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q   <= S_IF;
         wcnt_q <= 8'd0;
         code_q <= EXC_NONE;
         run_q  <= 1'b0;
      end else begin
         run_q  <= 1'b1;
         st_q   <= st_d;
         code_q <= code_d;
         if (st_d != st_q)
            wcnt_q <= 8'd0;
         else if (run_q && !mem_ready && (st_q == S_IF || st_q == S_MEM))
            wcnt_q <= wcnt_q + 8'd1;
      end
   end

   assign exc_code = code_q;
   assign state    = st_q;

endmodule

// File: tb/tb_cpu_ctl_mc.sv
// Directed bench for cpu_ctl_mc: a per-instruction trace model built from the
// instruction-class rules, compared against the DUT every cycle.
module tb_cpu_ctl_mc;

   localparam int TMO = 4;
   localparam int AW  = 5;

   localparam logic [5:0] R = 6'h00, J_JAL = 6'h03, BEQ = 6'h04, BNE = 6'h05;
   localparam logic [5:0] ADDI = 6'h08, SLTIU = 6'h0b, ANDI = 6'h0c, LUI = 6'h0f;
   localparam logic [5:0] LW = 6'h23, SW = 6'h2b;
   localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_NOR = 6'h27;
   localparam logic [5:0] F_SLTU = 6'h2b, F_SRA = 6'h03, F_JR = 6'h08;

   logic clk = 1'b0;
   logic rst_n;
   logic [5:0] op = '0, func = '0;
   logic equal_result = 1'b0, mem_ready = 1'b0;
   logic mem_rd, mem_wr, iord, ir_we, pc_we, jr, jal, lw, wreg;
   logic rdorrt, se, sa, iorr, exc, retire;
   logic [1:0] pcsrc, exc_code;
   logic [AW-1:0] aluc;
   logic [2:0] state;

   always #5 clk = ~clk;

   cpu_ctl_mc #(.MEM_TIMEOUT(TMO), .ALUC_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .func(func),
      .equal_result(equal_result), .mem_ready(mem_ready),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .iord(iord), .ir_we(ir_we),
      .pc_we(pc_we), .pcsrc(pcsrc), .jr(jr), .jal(jal), .lw(lw),
      .wreg(wreg), .rdorrt(rdorrt), .se(se), .sa(sa), .iorr(iorr),
      .aluc(aluc), .exc(exc), .exc_code(exc_code), .retire(retire),
      .state(state)
   );

   typedef struct {
      logic [2:0] st;
      logic       rdy, mem_rd, mem_wr, iord, ir_we, pc_we;
      logic [1:0] pcsrc;
      logic       wreg, exc;
      logic [1:0] code;
      logic       retire;
   } rec_t;

   rec_t       trace[$];
   rec_t       exp_q[$];
   logic [1:0] m_code = 2'd0;
   int         n_chk = 0, n_pass = 0;
   string      cur = "";

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] x);
      n_chk++;
      if (a === x) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, a, x);
   endtask

   function automatic rec_t mk(input logic [2:0] st);
      rec_t r;
      r = '{default: '0};
      r.st   = st;
      r.code = m_code;
      return r;
   endfunction

   // A memory wait of w not-ready cycles; times out when w reaches TMO.
   task automatic mem_phase(input logic [2:0] st, input logic rd, input logic wr,
                            input logic io, input int w, output bit to);
      rec_t r;
      int   n;
      to = (w >= TMO);
      n  = to ? TMO : w + 1;
      for (int i = 0; i < n; i++) begin
         r = mk(st);
         r.mem_rd = rd; r.mem_wr = wr; r.iord = io;
         r.rdy = (!to && i == n - 1);
         trace.push_back(r);
      end
   endtask

   task automatic push_exc(input logic [1:0] c);
      rec_t r;
      m_code = c;
      r = mk(3'd5);
      r.exc = 1'b1; r.pc_we = 1'b1; r.pcsrc = 2'd3;
      trace.push_back(r);
   endtask

   task automatic build(input logic [5:0] o, input logic [5:0] f, input logic eq,
                        input int if_w, input int mem_w);
      bit   to, isr, legal, jmp, br, mem;
      rec_t r;
      isr   = (o == 6'h00);
      legal = isr ? (f inside {6'h00, 6'h02, 6'h03, 6'h08, 6'h20, 6'h21, 6'h22,
                               6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b})
                  : (o inside {6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0a,
                               6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h23, 6'h2b});
      jmp = (o == 6'h02) || (o == 6'h03) || (isr && f == 6'h08);
      br  = (o == 6'h04) || (o == 6'h05);
      mem = (o == 6'h23) || (o == 6'h2b);
      mem_phase(3'd0, 1'b1, 1'b0, 1'b0, if_w, to);
      if (to) begin push_exc(2'd2); return; end
      r = trace.pop_back();
      r.ir_we = 1'b1; r.pc_we = 1'b1; r.pcsrc = 2'd0;
      trace.push_back(r);
      r = mk(3'd1);
      if (!legal) begin trace.push_back(r); push_exc(2'd1); return; end
      if (jmp) begin
         r.pc_we = 1'b1; r.pcsrc = 2'd2; r.wreg = (o == 6'h03); r.retire = 1'b1;
         trace.push_back(r);
         return;
      end
      trace.push_back(r);
      r = mk(3'd2);
      if (br) begin
         r.pc_we = (o == 6'h04) ? eq : !eq;
         r.pcsrc = 2'd1; r.retire = 1'b1;
         trace.push_back(r);
         return;
      end
      trace.push_back(r);
      if (mem) begin
         mem_phase(3'd3, o == 6'h23, o == 6'h2b, 1'b1, mem_w, to);
         if (to) begin push_exc(2'd2); return; end
         if (o == 6'h2b) begin
            r = trace.pop_back();
            r.retire = 1'b1;
            trace.push_back(r);
            return;
         end
      end
      r = mk(3'd4);
      r.wreg = 1'b1; r.retire = 1'b1;
      trace.push_back(r);
   endtask

   task automatic run(input string nm, input logic [5:0] o, input logic [5:0] f,
                      input logic eq, input int if_w, input int mem_w,
                      input int maxc, output int n);
      trace.delete();
      build(o, f, eq, if_w, mem_w);
      n   = trace.size();
      cur = nm;
      op = o; func = f; equal_result = eq;
      for (int i = 0; i < n && i < maxc; i++) begin
         mem_ready = trace[i].rdy;
         exp_q.push_back(trace[i]);
         @(posedge clk); #1;
      end
      mem_ready = 1'b0;
   endtask

   // pcsrc only matters when a PC write happens, iord only during an access.
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         rec_t e;
         logic [14:0] a, x;
         e = exp_q.pop_front();
         x = {e.st, e.mem_rd, e.mem_wr, e.iord & (e.mem_rd | e.mem_wr), e.ir_we,
              e.pc_we, e.pc_we ? e.pcsrc : 2'b00, e.wreg, e.exc, e.code, e.retire};
         a = {state, mem_rd, mem_wr, iord & (e.mem_rd | e.mem_wr), ir_we,
              pc_we, e.pc_we ? pcsrc : 2'b00, wreg, exc, exc_code, retire};
         chk(cur, 32'(a), 32'(x));
      end
   end

   task automatic chk_dec(input string nm, input logic [5:0] o, input logic [5:0] f,
                          input bit use_alu, input logic [AW-1:0] x_alu,
                          input logic [6:0] x_flags);
      op = o; func = f; #1;
      if (use_alu) chk({nm, "_aluc"}, 32'(aluc), 32'(x_alu));
      chk({nm, "_flags"}, {25'd0, rdorrt, se, sa, iorr, jr, jal, lw}, {25'd0, x_flags});
   endtask

   task automatic release_rst();
      mem_ready = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("rel_mem_rd_low", 32'(mem_rd), 32'd0);
      @(posedge clk); #1;
      chk("rel_mem_rd_high", 32'(mem_rd), 32'd1);
      m_code = 2'd0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int n;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_strobes", {23'd0, mem_rd, mem_wr, ir_we, pc_we, wreg, exc, retire, exc_code},
          32'd0);

      // flags: rdorrt se sa iorr jr jal lw
      chk_dec("add",   R,     F_ADD,  1, 5'd0,  7'b1000000);
      chk_dec("sub",   R,     F_SUB,  1, 5'd1,  7'b1000000);
      chk_dec("nor",   R,     F_NOR,  1, 5'd5,  7'b1000000);
      chk_dec("sltu",  R,     F_SLTU, 1, 5'd7,  7'b1000000);
      chk_dec("sra",   R,     F_SRA,  1, 5'd10, 7'b1010000);
      chk_dec("jr",    R,     F_JR,   0, 5'd0,  7'b0000100);
      chk_dec("addi",  ADDI,  6'h00,  1, 5'd0,  7'b0101000);
      chk_dec("andi",  ANDI,  6'h00,  1, 5'd2,  7'b0001000);
      chk_dec("lui",   LUI,   6'h00,  1, 5'd11, 7'b0001000);
      chk_dec("sltiu", SLTIU, 6'h00,  1, 5'd7,  7'b0101000);
      chk_dec("lw",    LW,    6'h00,  1, 5'd0,  7'b0101001);
      chk_dec("sw",    SW,    6'h00,  1, 5'd0,  7'b0101000);
      chk_dec("beq",   BEQ,   6'h00,  1, 5'd1,  7'b0000000);
      chk_dec("jal",   J_JAL, 6'h00,  0, 5'd0,  7'b0000010);

      release_rst();

      run("add", R, F_ADD, 1'b0, 0, 0, 99, n);
      chk("model_add_len", 32'(n), 32'd4);
      chk("model_add_wb", {27'd0, trace[3].st, trace[3].wreg, trace[3].retire}, 32'b10011);
      run("lw_wait3", LW, 6'h00, 1'b0, 0, 3, 99, n);
      chk("model_lw_len", 32'(n), 32'd8);
      run("beq_taken", BEQ, 6'h00, 1'b1, 0, 0, 99, n);
      chk("model_beq_t", {29'd0, trace[2].pc_we, trace[2].pcsrc}, 32'b101);
      run("beq_not", BEQ, 6'h00, 1'b0, 0, 0, 99, n);
      chk("model_beq_nt", {30'd0, trace[2].pc_we, trace[2].retire}, 32'b01);
      run("bne_taken", BNE, 6'h00, 1'b0, 1, 0, 99, n);
      run("jal", J_JAL, 6'h00, 1'b0, 0, 0, 99, n);
      chk("model_jal_len", 32'(n), 32'd2);
      run("jr", R, F_JR, 1'b0, 0, 0, 99, n);
      run("ill_op", 6'h3f, 6'h00, 1'b0, 0, 0, 99, n);
      chk("model_ill_code", {28'd0, trace[2].st == 3'd5, trace[2].retire, trace[2].code},
          32'b1001);
      run("ill_func", R, 6'h01, 1'b0, 0, 0, 99, n);
      run("sw_wait", SW, 6'h00, 1'b0, 2, 1, 99, n);
      chk("model_sw_len", 32'(n), 32'd7);
      run("if_timeout", R, F_ADD, 1'b0, 99, 0, 99, n);
      chk("model_if_tmo", {24'd0, 6'(n), trace[4].code}, {24'd0, 6'd5, 2'd2});
      run("if_ready_4th", R, F_ADD, 1'b0, 3, 0, 99, n);
      chk("model_if_late_len", 32'(n), 32'd7);
      run("mem_timeout", LW, 6'h00, 1'b0, 0, 99, 99, n);
      run("addi", ADDI, 6'h00, 1'b0, 0, 0, 99, n);

      // Abandon a store mid-access with an asynchronous reset.
      run("sw_rst", SW, 6'h00, 1'b0, 0, 99, 3, n);
      #1;
      chk("mid_mem_state", 32'(state), 32'd3);
      chk("mid_mem_wr", 32'(mem_wr), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_mem_wr_drop", {30'd0, mem_wr, mem_rd}, 32'd0);
      chk("rst_mid_state", 32'(state), 32'd0);
      chk("rst_mid_quiet", {28'd0, retire, exc, exc_code}, 32'd0);
      release_rst();
      run("add_after_rst", R, F_ADD, 1'b0, 0, 0, 99, n);

      @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/cpu_ctl_mc.md
CPU_CTL_MC -- requirements
Module: cpu_ctl_mc

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 16, giving the maximum number of cycles it waits for mem_ready before raising a bus fault; legal values are 2..255.
REQ-002 The block SHALL have parameter ALUC_W, default 5, giving the width of aluc.
REQ-003 The block SHALL use one clock and an asynchronous active-low reset, with ports as follows.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- op  in  6  opcode field of the instruction register.
- func  in  6  function field of the instruction register.
- equal_result  in  1  register-compare result (rs==rt).
- mem_ready  in  1  memory completes the current access this cycle.
- mem_rd, mem_wr  out  1  memory read and write request; level-held until mem_ready.
- iord  out  1  memory address select: 0=PC, 1=ALU result.
- ir_we, pc_we  out  1  write enables for the instruction register and the PC.
- pcsrc  out  2  next-PC select: 0=PC+4, 1=branch target, 2=jump/jr target (jr asserted), 3=exception vector.
- jr, jal, lw  out  1  decoded class strobes, valid in ID..WB.
- wreg, rdorrt, se, sa, iorr  out  1  register-write, rd-select, sign-extend, shamt-select, immediate-operand.
- aluc  out  ALUC_W  ALU operation.
- exc  out  1  exception pulse.
- exc_code  out  2  exception code: 1=illegal opcode, 2=bus timeout; held until the next exception.
- retire  out  1  one-cycle pulse when an instruction completes.
- state  out  3  current FSM state, for debug.

Function
REQ-004 The FSM SHALL have the states IF=0, ID=1, EX=2, MEM=3, WB=4 and EXC=5; codes 6..7 SHALL go to IF.
REQ-005 In IF the block SHALL hold mem_rd=1 and iord=0; on mem_ready it SHALL assert ir_we=1 and pc_we=1 with pcsrc=0 for that cycle and go to ID.
REQ-006 In ID the block SHALL handle each instruction class as follows.
- j and jal: pc_we=1 with pcsrc=2; jal also asserts wreg=1; retire; go to IF.
- jr: pc_we=1 with pcsrc=2; retire; go to IF.
- Illegal opcode or func: go to EXC with exc_code=1.
- All other instructions: go to EX.
REQ-007 The legal instruction set SHALL be the following.
- R-type: add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, jr.
- I-type: addi, addiu, andi, ori, xori, lui, slti, sltiu, lw, sw, beq, bne.
- J-type: j, jal.
REQ-008 In EX a beq or bne SHALL assert pc_we=1 with pcsrc=1 when (beq & equal_result) | (bne & ~equal_result), then retire and go to IF; lw and sw SHALL go to MEM; every other instruction SHALL go to WB.
REQ-009 In MEM the block SHALL assert iord=1 with mem_rd=lw and mem_wr=sw; on mem_ready, sw SHALL retire and go to IF, and lw SHALL go to WB.
REQ-010 In WB the block SHALL assert wreg=1 and retire, then go to IF.
REQ-011 Decode outputs SHALL be combinational from op and func in every state.
- rdorrt = R-type and not jr.
- se = addi, addiu, lw, sw, slti or sltiu.
- sa = sll, srl or sra.
- iorr = I-type and not branch.
REQ-012 The wait counter SHALL clear on entry to IF or MEM and SHALL increment on each cycle in which mem_ready=0.
- When it reaches MEM_TIMEOUT-1 with mem_ready still 0, the block SHALL go to EXC with exc_code=2, dropping mem_rd and mem_wr on the next cycle.
- mem_ready in the same cycle as the timeout SHALL win: the access completes and no exception is raised.
REQ-013 EXC SHALL last one cycle with exc=1, pc_we=1 and pcsrc=3, then go to IF; it SHALL NOT assert retire.
REQ-014 Outside their stated states, all write strobes (pc_we, ir_we, wreg, mem_wr) SHALL be 0.
REQ-015 The ALU operation codes SHALL be ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, SLT=6, SLTU=7, SLL=8, SRL=9, SRA=10, LUI=11.
- Branches SHALL use SUB.
- lw and sw SHALL use ADD.

Reset
REQ-016 While rst_n=0 the block SHALL force state=IF, clear the wait counter, set exc_code=0, and drive every strobe to 0; mem_rd SHALL rise on the first clock after release.
REQ-017 A reset asserted mid-access SHALL drop mem_rd and mem_wr asynchronously, and the instruction in flight SHALL be abandoned without retiring.

Structure
REQ-018 The shared package SHALL hold the state encoding, the aluc codes, the pcsrc and exc_code encodings, and the opcode and func constants.
REQ-019 The ALU decode SHALL be a sub-module alu_dec (op, func -> aluc), parametrised by ALUC_W.

Verification
REQ-020 The bench SHALL cover the following directed scenarios.
- add with mem_ready=1 throughout: states IF,ID,EX,WB; wreg=1 and retire in cycle 4; aluc=0; rdorrt=1.
- lw with 3 wait cycles in MEM: mem_rd held 4 cycles with iord=1; then WB asserts wreg=1; total 5+3 cycles.
- beq with equal_result=1: pc_we=1 and pcsrc=1 in EX. Repeat with equal_result=0: pc_we=0 in EX; retire in both cases.
- jal: ID asserts pc_we=1, pcsrc=2 and wreg=1; next state IF; 2 cycles total.
- op=6'b111111: EXC with exc=1, exc_code=1, pcsrc=3; no retire.
- MEM_TIMEOUT=4 and mem_ready held 0 in IF: EXC on the 5th cycle with exc_code=2. Repeat with mem_ready on the 4th cycle: no exception. Reset asserted mid-MEM: mem_wr drops immediately and state=IF.
